// File: rtl/cfg_load_arbiter.sv
// cfg_load_arbiter
//   Queues load commands for up to N_CFG stored field configurations and grants
//   them one at a time to the field-config loader, lowest index first.
//
// Ports
//   clk                 system clock, rising edge
//   rst                 asynchronous, active-high reset
//   i_cmd_load_cfg      level command per configuration (bit k -> configuration k+1)
//   i_FCL_allowed       loader may start now (field engine halted)
//   i_is_loading        loader busy, high for the whole load
//   o_go                start strobe to the loader (combinational in REQ)
//   o_cur_load_cfg_req  granted configuration code, 0 = no request
//   o_pending           queued, not-yet-granted commands
//   o_busy              state is not IDLE
//   o_timeout           one-cycle pulse when a grant is aborted by the start timeout
//   o_dbg_state         current FSM state (IDLE=0, REQ=1, START=2, LOAD=3)
//
// Handshake: in REQ the arbiter offers a grant; o_go = i_FCL_allowed, and the
// grant is taken on the first rising edge with o_go high. After that edge the
// loader is expected to raise i_is_loading (immediately or within the start
// timeout) and hold it for the whole load; the load ends at the first edge
// that samples i_is_loading low.

module cfg_load_arbiter #(
  parameter int N_CFG         = 4,
  parameter int REQ_W         = $clog2(N_CFG + 1),
  parameter int START_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CFG-1:0] i_cmd_load_cfg,
  input  logic             i_FCL_allowed,
  input  logic             i_is_loading,
  output logic             o_go,
  output logic [REQ_W-1:0] o_cur_load_cfg_req,
  output logic [N_CFG-1:0] o_pending,
  output logic             o_busy,
  output logic             o_timeout,
  output logic [1:0]       o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_START = 2'd2,
    S_LOAD  = 2'd3
  } state_t;

  localparam int CNT_W = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
  localparam bit TO_EN = (START_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'((START_TIMEOUT > 0) ? START_TIMEOUT - 1 : 0);

  state_t           state_q;
  logic [N_CFG-1:0] cmd_q;
  logic [N_CFG-1:0] pending_q;
  logic [REQ_W-1:0] code_q;
  logic [CNT_W-1:0] cnt_q;
  logic             timeout_q;

  logic [N_CFG-1:0] rise;
  logic [N_CFG-1:0] avail;
  logic [N_CFG-1:0] win_onehot;
  logic [REQ_W-1:0] win_code;
  logic             go;

  // A held command triggers once; cmd_q resets to 0 so a command already
  // high at reset release counts as a rise.
  assign rise  = i_cmd_load_cfg & ~cmd_q;
  assign avail = pending_q | rise;

  // Fixed priority: scan from the top so the lowest set index wins last.
  always_comb begin
    win_onehot = '0;
    win_code   = '0;
    for (int i = N_CFG - 1; i >= 0; i--) begin
      if (avail[i]) begin
        win_onehot    = '0;
        win_onehot[i] = 1'b1;
        win_code      = REQ_W'(i + 1);
      end
    end
  end

  assign go = (state_q == S_REQ) && i_FCL_allowed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cmd_q     <= '0;
      pending_q <= '0;
      code_q    <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cmd_q     <= i_cmd_load_cfg;
      timeout_q <= 1'b0;
      // Rises are queued in every state; a rise for the granted
      // configuration re-queues it so it reloads afterwards.
      pending_q <= pending_q | rise;

      case (state_q)
        S_IDLE: begin
          if (|avail) begin
            code_q    <= win_code;
            pending_q <= avail & ~win_onehot;
            state_q   <= S_REQ;
          end
        end

        S_REQ: begin
          if (go) begin
            if (i_is_loading) begin
              state_q <= S_LOAD;
            end else begin
              state_q <= S_START;
              cnt_q   <= '0;
            end
          end
        end

        S_START: begin
          if (i_is_loading) begin
            // Loader start on the abort edge itself still wins.
            state_q <= S_LOAD;
          end else if (TO_EN && (cnt_q == TO_LAST)) begin
            // Abandon the grant; the request is not re-queued.
            state_q   <= S_IDLE;
            code_q    <= '0;
            timeout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        S_LOAD: begin
          if (!i_is_loading) begin
            state_q <= S_IDLE;
            code_q  <= '0;
          end
        end

        default: begin
          state_q <= S_IDLE;
          code_q  <= '0;
        end
      endcase
    end
  end

  assign o_go               = go;
  assign o_cur_load_cfg_req = code_q;
  assign o_pending          = pending_q;
  assign o_busy             = (state_q != S_IDLE);
  assign o_timeout          = timeout_q;
  assign o_dbg_state        = state_q;

endmodule
